// File: rtl/bus_req_arbiter.sv
// bus_req_arbiter: per-processor request queues feeding one bus through a round-robin issue FSM
module bus_req_arbiter #(
   parameter  int NUM_PROC   = 4,
   parameter  int FIFO_DEPTH = 4,
   localparam int DEST_W     = $clog2(NUM_PROC) + 1,
   localparam int SRC_W      = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PROC-1:0]              i_enq_valid,
   input  logic [NUM_PROC-1:0][DEST_W-1:0]  i_enq_dest,
   output logic [NUM_PROC-1:0]              o_enq_ready,
   output logic                             o_bus_request,
   output logic [SRC_W-1:0]                 o_bus_src,
   output logic [DEST_W-1:0]                o_bus_dest,
   input  logic                             i_processed_request,
   output logic [NUM_PROC-1:0]              o_enq_drop
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   typedef enum logic {IDLE, ISSUE} state_t;
   state_t                  r_state, w_state_nxt;
   logic [DEST_W-1:0]       r_mem    [NUM_PROC][FIFO_DEPTH];
   logic [PTR_W-1:0]        r_wr_ptr [NUM_PROC];
   logic [PTR_W-1:0]        r_rd_ptr [NUM_PROC];
   logic [CNT_W-1:0]        r_cnt    [NUM_PROC];
   logic [NUM_PROC-1:0]     w_push, w_pop, w_nonempty, r_drop;
   logic [2*NUM_PROC-1:0]   w_dbl;
   logic [SRC_W-1:0]        r_last, w_last_nxt, r_src, w_src_nxt, w_gnt, w_off;
   logic [SRC_W:0]          w_sum;
   logic [DEST_W-1:0]       r_dest, w_dest_nxt;
   logic                    w_any;

   assign o_bus_request = (r_state == ISSUE);
   assign o_bus_src     = r_src;
   assign o_bus_dest    = r_dest;
   assign o_enq_drop    = r_drop;

   // queue status and handshake strobes; ready looks only at registered counts
   always_comb begin
      o_enq_ready = '0;
      w_nonempty  = '0;
      w_push      = '0;
      w_pop       = '0;
      for (int i = 0; i < NUM_PROC; i++) begin
         o_enq_ready[i] = r_cnt[i] < CNT_W'(FIFO_DEPTH);
         w_nonempty[i]  = r_cnt[i] != '0;
         w_push[i]      = i_enq_valid[i] & o_enq_ready[i];
         w_pop[i]       = (r_state == ISSUE) & i_processed_request & (r_src == SRC_W'(i));
      end
   end

   // queue storage, written at the tail; contents need no reset since counts gate every read
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PROC; i++)
         if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= i_enq_dest[i];
   end

   // pointers, occupancy counts and overflow-drop pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop <= '0;
         for (int i = 0; i < NUM_PROC; i++) begin
            r_wr_ptr[i] <= '0;
            r_rd_ptr[i] <= '0;
            r_cnt[i]    <= '0;
         end
      end else begin
         r_drop <= i_enq_valid & ~o_enq_ready;
         for (int i = 0; i < NUM_PROC; i++) begin
            r_wr_ptr[i] <= w_push[i] ? r_wr_ptr[i] + PTR_W'(1) : r_wr_ptr[i];
            r_rd_ptr[i] <= w_pop[i] ? r_rd_ptr[i] + PTR_W'(1) : r_rd_ptr[i];
            r_cnt[i]    <= r_cnt[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
         end
      end
   end

   // round-robin pick: rotate the non-empty mask so the slot after the last grant sits at bit 0
   always_comb begin
      w_any = |w_nonempty;
      w_dbl = {w_nonempty, w_nonempty} >> (r_last + SRC_W'(1));
      w_off = '0;
      for (int k = NUM_PROC - 1; k >= 0; k--)
         if (w_dbl[k]) w_off = SRC_W'(k);
      w_sum = (SRC_W+1)'(r_last) + (SRC_W+1)'(w_off) + (SRC_W+1)'(1);
      w_gnt = (w_sum >= (SRC_W+1)'(NUM_PROC)) ? SRC_W'(w_sum - (SRC_W+1)'(NUM_PROC)) : SRC_W'(w_sum);
   end

   // next state: grant from IDLE, hold in ISSUE until the bus completes, then one bubble in IDLE
   always_comb begin
      w_state_nxt = r_state;
      w_src_nxt   = r_src;
      w_dest_nxt  = r_dest;
      w_last_nxt  = r_last;
      if (r_state == IDLE) begin
         if (w_any) begin
            w_state_nxt = ISSUE;
            w_src_nxt   = w_gnt;
            w_dest_nxt  = r_mem[w_gnt][r_rd_ptr[w_gnt]];
         end
      end else if (i_processed_request) begin
         w_state_nxt = IDLE;
         w_last_nxt  = r_src;
         w_src_nxt   = '0;
         w_dest_nxt  = '0;
      end
   end

   // FSM registers; last grant resets to the top index so processor 0 wins first
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_src   <= '0;
         r_dest  <= '0;
         r_last  <= SRC_W'(NUM_PROC - 1);
      end else begin
         r_state <= w_state_nxt;
         r_src   <= w_src_nxt;
         r_dest  <= w_dest_nxt;
         r_last  <= w_last_nxt;
      end
   end
endmodule

// File: doc/bus_req_arbiter.md
BUS_REQ_ARBITER -- requirements
Module: bus_req_arbiter

Interface
REQ-001 Parameter NUM_PROC, default 4, is the number of processors feeding the bus.
REQ-002 Parameter FIFO_DEPTH, default 4, is the entries per processor queue; power of two, at least 2.
REQ-003 Derived DEST_W = $clog2(NUM_PROC)+1; destination value NUM_PROC means memory/broadcast.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enq_valid  input  [NUM_PROC]  per-processor request-enqueue strobe.
REQ-007 enq_dest  input  [NUM_PROC][DEST_W]  per-processor destination, sampled with enq_valid.
REQ-008 enq_ready  output  [NUM_PROC]  per-processor queue not full.
REQ-009 bus_request  output  1  request presented to the bus interconnect.
REQ-010 bus_src  output  $clog2(NUM_PROC)  requesting processor index.
REQ-011 bus_dest  output  DEST_W  destination of the presented request.
REQ-012 processed_request  input  1  bus has accepted and completed the presented request.
REQ-013 enq_drop  output  [NUM_PROC]  one-cycle pulse: enq_valid seen while that queue was full; the request is discarded.

Function
REQ-014 Each processor SHALL own a FIFO_DEPTH-entry FIFO of DEST_W-bit destinations, with count width $clog2(FIFO_DEPTH)+1.
REQ-015 enq_ready[i] SHALL be 1 iff count[i] < FIFO_DEPTH, from registered state only (no same-cycle bypass from a pop).
REQ-016 An entry SHALL be written when enq_valid[i] && enq_ready[i]; write and read pointers wrap modulo FIFO_DEPTH.
REQ-017 enq_valid[i] with enq_ready[i]=0 SHALL leave queue i unchanged and pulse enq_drop[i] on the next cycle.
REQ-018 The FSM SHALL have two states: IDLE and ISSUE.
REQ-019 In IDLE, if any queue is non-empty, the FSM SHALL grant round-robin, searching from (last_grant+1) mod NUM_PROC upward with wrap.
REQ-020 On a grant, the FSM SHALL register bus_src and the head destination into bus_dest and move to ISSUE.
REQ-021 In ISSUE, bus_request SHALL be 1, and bus_src/bus_dest SHALL be held stable until processed_request is seen.
REQ-022 On processed_request in ISSUE, the FSM SHALL:
  - pop the head of queue bus_src;
  - set last_grant = bus_src;
  - drop bus_request on the next cycle;
  - return to IDLE (one bubble cycle between grants).
REQ-023 processed_request in IDLE SHALL be ignored.
REQ-024 Latency: an enqueue at edge t into an empty system SHALL give bus_request=1 after edge t+2.
REQ-025 A same-cycle enqueue and pop on one queue SHALL leave its count unchanged.
REQ-026 A queue at FIFO_DEPTH that is popped SHALL raise enq_ready the following cycle.
REQ-027 In IDLE or on reset, bus_src and bus_dest SHALL read 0.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL clear:
  - all FIFO pointers and counts;
  - state to IDLE;
  - last_grant to NUM_PROC-1, so processor 0 has first priority;
  - bus_request, bus_src, bus_dest and enq_drop to 0.
REQ-029 enq_ready SHALL read all ones after reset.
REQ-030 Reset during ISSUE SHALL discard the in-flight request and all queued entries; enq_valid during reset SHALL be ignored.

Verification
REQ-031 Single request: proc 0 enq dest 4 at cycle 1, processed_request at cycle 5 -> bus_request=1 on cycles 3-5 with bus_src=0, bus_dest=4; low at cycle 6; enq_ready=4'b1111 throughout.
REQ-032 Fairness: all four procs enq once in the same cycle, processed_request held 1 -> grant order 0,1,2,3, each grant separated by one idle cycle.
REQ-033 Round-robin wrap: after a grant to 2, enqueue procs 0 and 3 -> next grant is 3, then 0.
REQ-034 Full/drop: 5 back-to-back enqs on proc 1 with no processed_request:
  - enq_ready[1]=0 after the 4th;
  - the 5th pulses enq_drop[1];
  - exactly 4 grants to proc 1 in original dest order afterwards.
REQ-035 Reset mid-ISSUE: assert rst while bus_request=1 with 2 entries queued -> next cycle bus_request=0, enq_ready=1111; a later processed_request produces no grant.
REQ-036 Hold: processed_request kept 0 for 20 cycles in ISSUE -> bus_src/bus_dest constant; new enqueues on other procs cause no change.
